// File: rtl/gcd_share_scheduler_pkg.sv
// Shared types and defaults for the GCD core share scheduler.
package gcd_share_scheduler_pkg;

  localparam int unsigned DEF_N_REQ     = 2;
  localparam int unsigned DEF_W         = 4;
  localparam int unsigned DEF_GO_CYCLES = 3;
  localparam int unsigned DEF_WAIT_CYC  = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GO,
    ST_WAIT,
    ST_DONE,
    ST_BYPASS
  } state_t;

  // Bits needed to hold values 0..n-1 (at least 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gcd_share_scheduler_if.sv
// Requester-side and core-side signal bundle of the GCD share scheduler.
interface gcd_share_scheduler_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = 4
);
  logic [N_REQ-1:0]   req_i;
  logic [N_REQ*W-1:0] x_i;
  logic [N_REQ*W-1:0] y_i;
  logic [N_REQ-1:0]   ack_o;
  logic [N_REQ-1:0]   done_o;
  logic [W-1:0]       res_o;
  logic               busy_o;
  logic [W-1:0]       core_x_o;
  logic [W-1:0]       core_y_o;
  logic               core_go_o;
  logic [W-1:0]       core_d_i;

  modport master (
    output req_i, x_i, y_i, core_d_i,
    input  ack_o, done_o, res_o, busy_o, core_x_o, core_y_o, core_go_o
  );

  modport slave (
    input  req_i, x_i, y_i, core_d_i,
    output ack_o, done_o, res_o, busy_o, core_x_o, core_y_o, core_go_o
  );
endinterface

// File: rtl/gcd_share_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import gcd_share_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned PW   = cnt_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_idx,
  output logic             valid
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr) + i) % N_REQ;
      if (!valid && req[idx[PW-1:0]]) begin
        valid                 = 1'b1;
        grant[idx[PW-1:0]]    = 1'b1;
        grant_idx             = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/gcd_share_scheduler.sv
// Time-shares one GCD core between N_REQ requesters with round-robin arbitration
// and a fixed worst-case wait, since the core has no completion flag.
module gcd_share_scheduler
  import gcd_share_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned W         = DEF_W,
  parameter int unsigned GO_CYCLES = DEF_GO_CYCLES,
  parameter int unsigned WAIT_CYC  = DEF_WAIT_CYC
) (
  input  logic                  CLK,
  input  logic                  RESET,
  gcd_share_scheduler_if.slave  bus
);

  localparam int unsigned PW = cnt_width(N_REQ);
  localparam int unsigned CW = cnt_width((GO_CYCLES > WAIT_CYC) ? GO_CYCLES : WAIT_CYC);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    job_idx;
  logic [N_REQ-1:0] job_oh;
  logic [W-1:0]     xq;
  logic [W-1:0]     yq;
  logic [CW-1:0]    cnt;

  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic             grant_valid;
  logic [W-1:0]     x_sel;
  logic [W-1:0]     y_sel;
  logic [PW-1:0]    ptr_next;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (bus.req_i),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  always_comb begin
    x_sel    = bus.x_i[32'(grant_idx) * W +: W];
    y_sel    = bus.y_i[32'(grant_idx) * W +: W];
    ptr_next = (job_idx == PW'(N_REQ - 1)) ? '0 : job_idx + PW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      job_idx       <= '0;
      job_oh        <= '0;
      xq            <= '0;
      yq            <= '0;
      cnt           <= '0;
      bus.ack_o     <= '0;
      bus.done_o    <= '0;
      bus.res_o     <= '0;
      bus.busy_o    <= 1'b0;
      bus.core_x_o  <= '0;
      bus.core_y_o  <= '0;
      bus.core_go_o <= 1'b0;
    end else begin
      bus.ack_o  <= '0;
      bus.done_o <= '0;
      case (state)
        ST_IDLE: begin
          // busy stays high through the done cycle and drops on the following edge
          bus.busy_o <= grant_valid;
          if (grant_valid) begin
            bus.ack_o <= grant;
            job_idx   <= grant_idx;
            job_oh    <= grant;
            xq        <= x_sel;
            yq        <= y_sel;
            if (x_sel == '0 || y_sel == '0) begin
              state <= ST_BYPASS;
            end else begin
              bus.core_x_o <= x_sel;
              bus.core_y_o <= y_sel;
              state        <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          bus.core_go_o <= 1'b1;
          cnt           <= '0;
          state         <= ST_GO;
        end
        ST_GO: begin
          if (cnt == CW'(GO_CYCLES - 1)) begin
            bus.core_go_o <= 1'b0;
            cnt           <= '0;
            state         <= ST_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (cnt == CW'(WAIT_CYC - 1)) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          bus.res_o  <= bus.core_d_i;
          bus.done_o <= job_oh;
          ptr        <= ptr_next;
          state      <= ST_IDLE;
        end
        ST_BYPASS: begin
          bus.res_o  <= (xq == '0) ? yq : xq;
          bus.done_o <= job_oh;
          ptr        <= ptr_next;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_share_scheduler.sv
// Bench for gcd_share_scheduler: behavioural GCD core, scoreboard monitor,
// directed vector table, hand-written corner sequences and random traffic.
module tb_gcd_share_scheduler;

  localparam int unsigned N   = 2;
  localparam int unsigned W   = 4;
  localparam int unsigned GOC = 3;
  localparam int unsigned WC  = 20;
  localparam int          LAT = 1 + GOC + WC + 1;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #10 CLK = ~CLK;

  gcd_share_scheduler_if #(.N_REQ(N), .W(W)) bus ();

  gcd_share_scheduler #(
    .N_REQ    (N),
    .W        (W),
    .GO_CYCLES(GOC),
    .WAIT_CYC (WC)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int gcd_ref(input int a_in, input int b_in);
    int a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural core: clears d on go rise, presents gcd some cycles after go falls.
  logic       go_q = 1'b0;
  int         core_cd = 0;
  logic [W-1:0] core_res = '0;
  always @(posedge CLK) begin
    go_q <= bus.core_go_o;
    if (RESET) begin
      bus.core_d_i <= '0;
      core_cd      <= 0;
    end else if (bus.core_go_o && !go_q) begin
      bus.core_d_i <= '0;
      core_res     <= W'(gcd_ref(int'(bus.core_x_o), int'(bus.core_y_o)));
    end else if (!bus.core_go_o && go_q) begin
      core_cd <= 18;
    end else if (core_cd == 1) begin
      bus.core_d_i <= core_res;
      core_cd      <= 0;
    end else if (core_cd > 1) begin
      core_cd <= core_cd - 1;
    end
  end

  // Scoreboard: one job at a time, fixed latency, round-robin from last finisher + 1.
  bit           m_active = 0;
  bit           m_byp = 0;
  int           m_k = 0;
  int           m_acc = 0;
  int           m_ptr = 0;
  logic [W-1:0] m_x = '0;
  logic [W-1:0] m_y = '0;
  logic [W-1:0] m_res = '0;
  logic [N-1:0] e_ack, e_done;
  bit           e_busy, e_go, ops_chk;
  int           off;

  always @(negedge CLK) begin
    cyc++;
    if (RESET) begin
      chk("reset_outputs", {bus.ack_o, bus.done_o, bus.res_o, bus.busy_o,
                            bus.core_x_o, bus.core_y_o, bus.core_go_o}, 0);
      m_active = 0;
      m_ptr    = 0;
      m_res    = '0;
    end else begin
      e_ack = '0; e_done = '0; e_busy = 0; e_go = 0; ops_chk = 0;
      if (m_active) begin
        off     = cyc - m_acc;
        e_busy  = 1;
        ops_chk = !m_byp;
        if (off == (m_byp ? 1 : LAT)) begin
          e_done[m_k] = 1'b1;
          m_res       = W'(gcd_ref(int'(m_x), int'(m_y)));
          m_ptr       = (m_k + 1) % N;
          m_active    = 0;
        end else begin
          e_go = !m_byp && off >= 1 && off <= GOC;
        end
      end else if (bus.req_i != '0) begin
        for (int i = 0; i < N; i++) begin
          if (bus.req_i[(m_ptr + i) % N]) begin
            m_k = (m_ptr + i) % N;
            break;
          end
        end
        e_ack[m_k] = 1'b1;
        m_active   = 1;
        m_acc      = cyc;
        m_x        = bus.x_i[m_k*W +: W];
        m_y        = bus.y_i[m_k*W +: W];
        m_byp      = (m_x == 0) || (m_y == 0);
        e_busy     = 1;
        ops_chk    = !m_byp;
      end
      chk("ack_o", bus.ack_o, e_ack);
      chk("done_o", bus.done_o, e_done);
      chk("busy_o", bus.busy_o, e_busy);
      chk("core_go_o", bus.core_go_o, e_go);
      chk("res_o", bus.res_o, m_res);
      if (ops_chk) chk("core_ops", {bus.core_x_o, bus.core_y_o}, {m_x, m_y});
    end
  end

  task automatic set_req(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
    #1;
    bus.req_i[k]       = 1'b1;
    bus.x_i[k*W +: W]  = x;
    bus.y_i[k*W +: W]  = y;
  endtask

  task automatic drop_req(input int k);
    #1;
    bus.req_i[k] = 1'b0;
  endtask

  // Counts negedges until ack_o[k] (is_done=0) or done_o[k] (is_done=1) is seen.
  task automatic wait_bit(input bit is_done, input int k, input string name, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge CLK);
      n++;
      seen = is_done ? bus.done_o[k] : bus.ack_o[k];
    end
    chk({name, "_seen"}, seen, 1);
  endtask

  task automatic wait_any_ack(output int idx);
    int n;
    n = 0;
    idx = -1;
    while (idx < 0 && n < 200) begin
      @(negedge CLK);
      n++;
      if (bus.ack_o != '0) idx = bus.ack_o[1] ? 1 : 0;
    end
    chk("any_ack_seen", (idx >= 0), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.busy_o && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_idle", bus.busy_o, 0);
  endtask

  task automatic pulse_reset(input int cycles);
    #1 RESET = 1'b1;
    repeat (cycles) @(negedge CLK);
    #1 RESET = 1'b0;
  endtask

  typedef struct {
    int           k;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_res;
    int           exp_lat;
  } vec_t;

  vec_t vt[7];

  initial begin : stim
    int n, cnt_done, cnt_ack, idx;
    int order[4];

    vt[0] = '{0, 4'd8,  4'd12, 4'd4,  LAT};
    vt[1] = '{1, 4'd0,  4'd7,  4'd7,  1};
    vt[2] = '{0, 4'd0,  4'd0,  4'd0,  1};
    vt[3] = '{1, 4'd15, 4'd10, 4'd5,  LAT};
    vt[4] = '{0, 4'd9,  4'd0,  4'd9,  1};
    vt[5] = '{1, 4'd7,  4'd7,  4'd7,  LAT};
    vt[6] = '{0, 4'd13, 4'd1,  4'd1,  LAT};

    bus.req_i = '0;
    bus.x_i   = '0;
    bus.y_i   = '0;
    repeat (3) @(negedge CLK);
    #1 RESET = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      set_req(vt[i].k, vt[i].x, vt[i].y);
      wait_bit(0, vt[i].k, "vec_ack", n);
      chk("vec_ack_latency", n, 1);
      drop_req(vt[i].k);
      wait_bit(1, vt[i].k, "vec_done", n);
      chk("vec_done_latency", n, vt[i].exp_lat);
      chk("vec_res", bus.res_o, vt[i].exp_res);
    end

    // Same-cycle requests right after reset: requester 0 first, then 1.
    @(negedge CLK);
    pulse_reset(1);
    set_req(0, 4'd3, 4'd8);
    bus.req_i[1] = 1'b1;
    bus.x_i[W +: W] = 4'd15;
    bus.y_i[W +: W] = 4'd10;
    wait_bit(0, 0, "same_ack0", n);
    drop_req(0);
    wait_bit(1, 0, "same_done0", n);
    chk("same_res0", bus.res_o, 1);
    wait_bit(0, 1, "same_ack1", n);
    chk("same_ack1_after_done0", n, 1);
    drop_req(1);
    wait_bit(1, 1, "same_done1", n);
    chk("same_res1", bus.res_o, 5);

    // Both held high: grants alternate.
    set_req(0, 4'd6, 4'd4);
    set_req(1, 4'd9, 4'd6);
    for (int i = 0; i < 4; i++) wait_any_ack(order[i]);
    for (int i = 0; i < 4; i++) chk("alternate_grant", order[i], i % 2);
    drop_req(0);
    bus.req_i[1] = 1'b0;
    drain();

    // Reset during WAIT aborts the job; no done_o afterwards.
    @(negedge CLK);
    set_req(0, 4'd9, 4'd9);
    wait_bit(0, 0, "abort_ack", n);
    drop_req(0);
    repeat (10) @(negedge CLK);
    pulse_reset(2);
    cnt_done = 0;
    repeat (30) begin
      @(negedge CLK);
      if (bus.done_o != '0) cnt_done++;
    end
    chk("abort_no_done", cnt_done, 0);
    set_req(0, 4'd9, 4'd9);
    wait_bit(0, 0, "rereq_ack", n);
    drop_req(0);
    wait_bit(1, 0, "rereq_done", n);
    chk("rereq_latency", n, LAT);
    chk("rereq_res", bus.res_o, 9);

    // Request toggled while busy gives no extra ack.
    @(negedge CLK);
    set_req(1, 4'd12, 4'd8);
    wait_bit(0, 1, "toggle_ack", n);
    drop_req(1);
    cnt_ack = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus.ack_o != '0) cnt_ack++;
      #1 bus.req_i[1] = (i % 2 == 0) && (i < 10);
    end
    wait_bit(1, 1, "toggle_done", n);
    chk("toggle_res", bus.res_o, 4);
    chk("toggle_no_extra_ack", cnt_ack, 0);

    // Random traffic checked by the scoreboard.
    for (int c = 0; c < 500; c++) begin
      @(negedge CLK);
      #1;
      for (int k = 0; k < N; k++) begin
        if (!bus.req_i[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req_i[k]      = 1'b1;
            bus.x_i[k*W +: W] = W'($urandom_range(0, 15));
            bus.y_i[k*W +: W] = W'($urandom_range(0, 15));
          end
        end else if (bus.ack_o[k]) begin
          if ($urandom_range(0, 1) == 0) begin
            bus.req_i[k] = 1'b0;
          end else begin
            bus.x_i[k*W +: W] = W'($urandom_range(0, 15));
            bus.y_i[k*W +: W] = W'($urandom_range(0, 15));
          end
        end
      end
    end
    #1 bus.req_i = '0;
    @(negedge CLK);
    drain();

    idx = 0;
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
